// File: rtl/acc_pkg.sv
// Shared types and default widths for the accumulator feeder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package acc_pkg;

  // Default widths used by acc_feeder when the instantiator does not override them
  localparam int unsigned ACC_IN_DATA_WIDTH = 8;
  localparam int unsigned ACC_CNT_WIDTH     = 16;
  localparam int unsigned ACC_FIFO_DEPTH    = 4;

  // Job sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FEED = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } acc_state_t;

endpackage

// File: rtl/acc_fifo.sv
// Small synchronous FIFO holding operands ahead of the accumulator.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored.
module acc_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_dat,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_dat,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;
  logic [AW-1:0]    w_wr_ptr_inc;
  logic [AW-1:0]    w_rd_ptr_inc;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dat   = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Explicit wrap so a non-power-of-two depth would still index correctly
  assign w_wr_ptr_inc = (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
  assign w_rd_ptr_inc = (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);

  // Storage array carries no reset; only the pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_dat;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= w_wr_ptr_inc;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/acc_feeder.sv
// Buffers upstream operands and issues a job of len_i operands to an accumulator.
// Latency: one cycle from FIFO pop to valid_o/number_o; done_o one cycle after the DONE state.
// Backpressure: s_ready_o is the registered FIFO not-full; empty FIFO stalls issue with no timeout.
module acc_feeder
  import acc_pkg::*;
#(
  parameter int unsigned IN_DATA_WIDTH = ACC_IN_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH     = ACC_CNT_WIDTH,
  parameter int unsigned FIFO_DEPTH    = ACC_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start_i,
  input  logic [CNT_WIDTH-1:0]     len_i,
  input  logic                     s_valid_i,
  input  logic [IN_DATA_WIDTH-1:0] s_data_i,
  output logic                     s_ready_o,
  output logic                     run_o,
  output logic                     valid_o,
  output logic [IN_DATA_WIDTH-1:0] number_o,
  input  logic                     acc_valid_i,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);

  acc_state_t               r_state;
  acc_state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0]     r_len;
  logic [CNT_WIDTH-1:0]     r_cnt;
  logic [CNT_WIDTH-1:0]     w_cnt_inc;
  logic                     r_s_ready;
  logic                     r_run;
  logic                     r_vld;
  logic                     r_done;
  logic [IN_DATA_WIDTH-1:0] r_number;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_fifo_full;
  logic                     w_fifo_empty;
  logic [IN_DATA_WIDTH-1:0] w_fifo_dat;
  logic [FCW-1:0]           w_fifo_count;
  logic [FCW-1:0]           w_fifo_count_nxt;
  logic                     w_job_start;
  logic                     w_last_pop;

  // Operand buffer; accepts in every state so upstream can prefill before a job
  acc_fifo #(
    .WIDTH (IN_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_dat   (s_data_i),
    .i_pop   (w_pop),
    .o_dat   (w_fifo_dat),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // Ready is registered, so it already reflects this cycle's occupancy; the full
  // term only matters if the two ever disagreed
  assign w_push = s_valid_i && r_s_ready && !w_fifo_full;

  // Pops read the registered head only, so a same-cycle push is never bypassed
  assign w_pop = (r_state == ST_FEED) && !w_fifo_empty;

  assign w_fifo_count_nxt = w_fifo_count + FCW'(w_push) - FCW'(w_pop);

  // Counter wraps modulo 2^CNT_WIDTH; comparing the incremented value against
  // len lets the maximum length finish without the counter ever wrapping
  assign w_cnt_inc   = r_cnt + CNT_WIDTH'(1);
  assign w_last_pop  = w_pop && (w_cnt_inc == r_len);
  assign w_job_start = (r_state == ST_IDLE) && start_i;

  // Next-state selection; start_i only matters in IDLE, acc_valid_i only in WAIT
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_state_nxt = (len_i == '0) ? ST_DONE : ST_FEED;
        end
      end
      ST_FEED: begin
        if (w_last_pop) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (acc_valid_i) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Job length latch and issue counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len <= '0;
      r_cnt <= '0;
    end else if (w_job_start) begin
      r_len <= len_i;
      r_cnt <= '0;
    end else if (w_pop) begin
      r_cnt <= w_cnt_inc;
    end
  end

  // Registered operand stream; number_o keeps the last issued operand between beats
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld    <= 1'b0;
      r_number <= '0;
    end else begin
      r_vld <= w_pop;
      if (w_pop) begin
        r_number <= w_fifo_dat;
      end
    end
  end

  // Run spans FEED and WAIT; done pulses the cycle after the DONE state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_run  <= (w_state_nxt == ST_FEED) || (w_state_nxt == ST_WAIT);
      r_done <= (r_state == ST_DONE);
    end
  end

  // Ready held low through reset, then tracks next-cycle FIFO occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s_ready <= 1'b0;
    end else begin
      r_s_ready <= (w_fifo_count_nxt != FCW'(FIFO_DEPTH));
    end
  end

  assign s_ready_o = r_s_ready;
  assign run_o     = r_run;
  assign valid_o   = r_vld;
  assign number_o  = r_number;
  assign done_o    = r_done;
  assign busy_o    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_acc_feeder.sv
// Self-checking bench for acc_feeder: directed vector table, hand sequences, randomized jobs.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: the upstream driver holds data while s_ready_o is low.
module tb_acc_feeder;

  localparam int DW    = 8;
  localparam int CW    = 4;
  localparam int DEPTH = 4;
  localparam int NJOBS = 40;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start_i = 1'b0;
  logic [CW-1:0] len_i = '0;
  logic          s_valid_i = 1'b0;
  logic [DW-1:0] s_data_i = '0;
  logic          s_ready_o;
  logic          run_o;
  logic          valid_o;
  logic [DW-1:0] number_o;
  logic          acc_valid_i = 1'b0;
  logic          busy_o;
  logic          done_o;

  always #5 clk = ~clk;

  acc_feeder #(
    .IN_DATA_WIDTH (DW),
    .CNT_WIDTH     (CW),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_i     (start_i),
    .len_i       (len_i),
    .s_valid_i   (s_valid_i),
    .s_data_i    (s_data_i),
    .s_ready_o   (s_ready_o),
    .run_o       (run_o),
    .valid_o     (valid_o),
    .number_o    (number_o),
    .acc_valid_i (acc_valid_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  typedef struct {
    logic          sv;
    logic [DW-1:0] sd;
    logic          st;
    logic [CW-1:0] ln;
    logic          acc;
    logic [12:0]   exp;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {s_ready, run, valid, busy, done, number}
  function automatic logic [12:0] outs();
    return {s_ready_o, run_o, valid_o, busy_o, done_o, number_o};
  endfunction

  function automatic vec_t mk(input int sv, input int sd, input int st, input int ln, input int acc,
                              input int rdy, input int run, input int vld, input int bsy,
                              input int dn, input int num);
    vec_t v;
    v.sv  = sv[0];
    v.sd  = sd[7:0];
    v.st  = st[0];
    v.ln  = ln[3:0];
    v.acc = acc[0];
    v.exp = {rdy[0], run[0], vld[0], bsy[0], dn[0], num[7:0]};
    return v;
  endfunction

  vec_t          tbl[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_dat;
  logic [CW-1:0] cur_len;
  int            issued, jobs_started, jobs_done, wait_cnt, nv, last_c;
  bit            job_active, acc_sent;

  initial begin
    //           sv  sd     st ln acc | rdy run vld bsy dn num
    tbl.push_back(mk(0, 0,    0, 0, 0,  1, 0, 0, 0, 0, 8'h00)); // first edge after reset
    tbl.push_back(mk(1, 8'h01,0, 0, 0,  1, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 8'h02,0, 0, 0,  1, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 8'h03,0, 0, 0,  1, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0,    1, 3, 0,  1, 1, 0, 1, 0, 8'h00)); // start len 3
    tbl.push_back(mk(0, 0,    0, 0, 0,  1, 1, 1, 1, 0, 8'h01));
    tbl.push_back(mk(0, 0,    0, 0, 0,  1, 1, 1, 1, 0, 8'h02));
    tbl.push_back(mk(0, 0,    0, 0, 0,  1, 1, 1, 1, 0, 8'h03));
    tbl.push_back(mk(0, 0,    0, 0, 0,  1, 1, 0, 1, 0, 8'h03)); // WAIT
    tbl.push_back(mk(0, 0,    0, 0, 1,  1, 0, 0, 1, 0, 8'h03)); // acc_valid -> DONE
    tbl.push_back(mk(0, 0,    0, 0, 0,  1, 0, 0, 0, 1, 8'h03));
    tbl.push_back(mk(0, 0,    0, 0, 0,  1, 0, 0, 0, 0, 8'h03));
    tbl.push_back(mk(0, 0,    1, 0, 0,  1, 0, 0, 1, 0, 8'h03)); // len 0
    tbl.push_back(mk(0, 0,    0, 0, 0,  1, 0, 0, 0, 1, 8'h03));
    tbl.push_back(mk(0, 0,    0, 0, 0,  1, 0, 0, 0, 0, 8'h03));
    tbl.push_back(mk(1, 8'h10,0, 0, 0,  1, 0, 0, 0, 0, 8'h03)); // fill while idle
    tbl.push_back(mk(1, 8'h11,0, 0, 0,  1, 0, 0, 0, 0, 8'h03));
    tbl.push_back(mk(1, 8'h12,0, 0, 0,  1, 0, 0, 0, 0, 8'h03));
    tbl.push_back(mk(1, 8'h13,0, 0, 0,  0, 0, 0, 0, 0, 8'h03)); // full after 4th
    tbl.push_back(mk(1, 8'h14,0, 0, 0,  0, 0, 0, 0, 0, 8'h03)); // 5th held
    tbl.push_back(mk(1, 8'h14,1, 1, 0,  0, 1, 0, 1, 0, 8'h03)); // start len 1
    tbl.push_back(mk(1, 8'h14,0, 0, 0,  1, 1, 1, 1, 0, 8'h10)); // pop frees a slot
    tbl.push_back(mk(1, 8'h14,0, 0, 0,  0, 1, 0, 1, 0, 8'h10)); // 5th accepted
    tbl.push_back(mk(0, 0,    0, 0, 1,  0, 0, 0, 1, 0, 8'h10));
    tbl.push_back(mk(0, 0,    0, 0, 0,  0, 0, 0, 0, 1, 8'h10));
    tbl.push_back(mk(0, 0,    1, 4, 0,  0, 1, 0, 1, 0, 8'h10)); // drain leftovers
    tbl.push_back(mk(0, 0,    0, 0, 0,  1, 1, 1, 1, 0, 8'h11));
    tbl.push_back(mk(0, 0,    0, 0, 0,  1, 1, 1, 1, 0, 8'h12));
    tbl.push_back(mk(0, 0,    0, 0, 0,  1, 1, 1, 1, 0, 8'h13));
    tbl.push_back(mk(0, 0,    0, 0, 0,  1, 1, 1, 1, 0, 8'h14));
    tbl.push_back(mk(0, 0,    0, 0, 0,  1, 1, 0, 1, 0, 8'h14));
    tbl.push_back(mk(0, 0,    0, 0, 1,  1, 0, 0, 1, 0, 8'h14));
    tbl.push_back(mk(0, 0,    0, 0, 0,  1, 0, 0, 0, 1, 8'h14));

    // Reset values while reset is held
    #2;
    check("reset_outs", 32'(outs()), 0);
    step();
    step();
    check("reset_hold", 32'(outs()), 0);
    #2 reset_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < tbl.size(); i++) begin
      s_valid_i   = tbl[i].sv;
      s_data_i    = tbl[i].sd;
      start_i     = tbl[i].st;
      len_i       = tbl[i].ln;
      acc_valid_i = tbl[i].acc;
      step();
      check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end
    s_valid_i = 1'b0; start_i = 1'b0; acc_valid_i = 1'b0; len_i = '0;

    // len 4 with two idle cycles between operands; stray start len 9 during FEED
    start_i = 1'b1; len_i = 4'd4;
    step();
    start_i = 1'b0; len_i = '0;
    check("gap_busy", 32'(busy_o), 1);
    nv = 0; last_c = 0;
    for (int c = 0; c < 14; c++) begin
      s_valid_i = (c % 3 == 0) && (c < 12);
      s_data_i  = 8'(32'h40 + c / 3);
      start_i   = (c == 5);
      len_i     = (c == 5) ? 4'd9 : 4'd0;
      step();
      if (valid_o) begin
        check("gap_data", 32'(number_o), 32'h40 + nv);
        if (nv > 0) check("gap_spacing", c - last_c, 3);
        last_c = c;
        nv++;
      end
    end
    s_valid_i = 1'b0; start_i = 1'b0; len_i = '0;
    check("gap_count", nv, 4);
    check("gap_wait", 32'({busy_o, run_o, done_o}), 6);
    acc_valid_i = 1'b1;
    step();
    acc_valid_i = 1'b0;
    check("gap_acc", 32'({busy_o, run_o, done_o}), 4);
    step();
    check("gap_done", 32'({busy_o, done_o}), 1);
    step();
    check("gap_done_pulse", 32'(done_o), 0);

    // Reset in the middle of a job after 2 of 4 operands
    for (int i = 0; i < 4; i++) begin
      s_valid_i = 1'b1; s_data_i = 8'(32'h51 + i);
      step();
    end
    s_valid_i = 1'b0;
    start_i = 1'b1; len_i = 4'd4;
    step();
    start_i = 1'b0; len_i = '0;
    step();
    check("rst_op1", 32'({valid_o, number_o}), 32'h151);
    step();
    check("rst_op2", 32'({valid_o, number_o}), 32'h152);
    #2 reset_n = 1'b0;
    #1 check("rst_async", 32'(outs()), 0);
    step();
    step();
    check("rst_held", 32'(outs()), 0);
    #2 reset_n = 1'b1;
    step();
    check("rst_release", 32'(outs()), 32'h1000);
    start_i = 1'b1; len_i = 4'd1;
    step();
    start_i = 1'b0; len_i = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_fifo_empty", 32'({valid_o, done_o}), 0);
    end
    s_valid_i = 1'b1; s_data_i = 8'h66;
    step();
    s_valid_i = 1'b0;
    step();
    check("rst_new_op", 32'({valid_o, number_o}), 32'h166);
    acc_valid_i = 1'b1;
    step();
    acc_valid_i = 1'b0;
    step();
    check("rst_new_done", 32'(done_o), 1);

    // Randomized jobs against a queue-based reference
    reset_n = 1'b0;
    #12 reset_n = 1'b1;
    step();
    job_active = 0; acc_sent = 0; issued = 0; cur_len = '0;
    jobs_started = 0; jobs_done = 0; wait_cnt = 0;
    for (int cyc = 0; cyc < 20000 && jobs_done < NJOBS; cyc++) begin
      start_i = 1'b0; acc_valid_i = 1'b0; len_i = '0;
      if (!(s_valid_i && !s_ready_o)) begin
        s_valid_i = ($urandom_range(0, 1) == 1);
        s_data_i  = 8'($urandom);
      end
      if (s_valid_i && s_ready_o) exp_q.push_back(s_data_i);
      if (!job_active && !busy_o && jobs_started < NJOBS && $urandom_range(0, 3) == 0) begin
        cur_len    = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 6));
        start_i    = 1'b1;
        len_i      = cur_len;
        job_active = 1; acc_sent = 0; issued = 0;
        wait_cnt   = $urandom_range(0, 3);
        jobs_started++;
      end else if (job_active && issued < int'(cur_len)) begin
        if ($urandom_range(0, 7) == 0) begin
          start_i = 1'b1; len_i = 4'd9;
        end
        acc_valid_i = ($urandom_range(0, 7) == 0);
      end else if (job_active && cur_len != 0 && issued == int'(cur_len) && !acc_sent) begin
        if (wait_cnt == 0) begin
          acc_valid_i = 1'b1; acc_sent = 1;
        end else begin
          wait_cnt--;
        end
      end else if (!job_active) begin
        acc_valid_i = ($urandom_range(0, 7) == 0);
      end
      step();
      if (valid_o) begin
        check("rnd_valid_in_job", 32'(job_active), 1);
        check("rnd_run", 32'(run_o), 1);
        if (exp_q.size() == 0) begin
          check("rnd_underflow", 1, 0);
        end else begin
          exp_dat = exp_q.pop_front();
          check("rnd_data", 32'(number_o), 32'(exp_dat));
        end
        issued++;
      end
      if (done_o) begin
        check("rnd_done_in_job", 32'(job_active), 1);
        check("rnd_len", issued, int'(cur_len));
        check("rnd_run_at_done", 32'(run_o), 0);
        job_active = 0;
        jobs_done++;
      end
      check("rnd_busy", 32'(busy_o), 32'(job_active));
    end
    check("rnd_jobs_done", jobs_done, NJOBS);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
